// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Counter width depends on DMEM_RESP_RANDOM_STALL_EN (extra random stall cycles).
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback from bits 0,2,3,5 of a right-shifting register (taps 16,14,13,11).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

`ifdef DMEM_RESP_RANDOM_STALL_EN
    localparam int unsigned CNT_W = 6;
`else
    localparam int unsigned CNT_W = 4;
`endif

endpackage

// File: rtl/dmem_resp_lfsr.sv
// 16-bit Fibonacci LFSR supplying extra random stall cycles.
// Only instantiated when DMEM_RESP_RANDOM_STALL_EN is defined.
module dmem_resp_lfsr
    import dmem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] o_extra
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign o_extra = r_lfsr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with configurable stall latency and read-before-write.
// Define DMEM_RESP_RANDOM_STALL_EN to add 0..3 LFSR-driven stall cycles per request.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dcache_addr,
    input  logic [3:0]  dcache_we,
    input  logic        dcache_re,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      w_total;
    logic [31:0]           r_req_addr;
    logic [31:0]           r_req_din;
    logic [3:0]            r_req_we;
    logic                  r_req_re;
    logic [31:0]           r_dout;
    logic                  w_req;
    logic                  w_same;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_busy;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_op_din;
    logic [3:0]            w_op_we;
    logic                  w_op_re;

`ifdef DMEM_RESP_RANDOM_STALL_EN
    logic [1:0] w_extra;

    dmem_resp_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .o_extra (w_extra)
    );

    assign w_total = CNT_W'(LATENCY) + CNT_W'(w_extra);
`else
    assign w_total = CNT_W'(LATENCY);
`endif

    // Gating with reset_n keeps stall low and blocks array writes while reset is held.
    assign w_req    = reset_n & (dcache_re | (|dcache_we));
    assign w_same   = (dcache_addr == r_req_addr) && (dcache_we == r_req_we) &&
                      (dcache_re == r_req_re) && (dcache_din == r_req_din);
    assign w_accept = w_req && ((r_state == StIdle) || ((r_state == StResp) && !w_same));
    assign w_busy   = (r_state == StBusy);

    // Once in BUSY the latched request is authoritative.
    assign w_idx    = w_busy ? r_req_addr[DEPTH_LOG2-1:0] : dcache_addr[DEPTH_LOG2-1:0];
    assign w_op_din = w_busy ? r_req_din : dcache_din;
    assign w_op_we  = w_busy ? r_req_we  : dcache_we;
    assign w_op_re  = w_busy ? r_req_re  : dcache_re;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle, StResp: begin
                w_state_next = StIdle;
                if (w_accept) begin
                    if (w_total > CNT_W'(1)) begin
                        w_state_next = StBusy;
                        w_cnt_next   = w_total - CNT_W'(1);
                    end else if (w_total == CNT_W'(1)) begin
                        w_state_next = StResp;
                        w_cnt_next   = '0;
                    end
                end
            end
            StBusy: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = StResp;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        w_commit = 1'b0;
        if (w_busy) begin
            stall    = 1'b1;
            w_commit = (r_cnt <= CNT_W'(1));
        end else if (w_accept) begin
            stall    = (w_total != '0);
            w_commit = (w_total <= CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_addr <= '0;
            r_req_din  <= '0;
            r_req_we   <= '0;
            r_req_re   <= 1'b0;
        end else if (w_accept) begin
            r_req_addr <= dcache_addr;
            r_req_din  <= dcache_din;
            r_req_we   <= dcache_we;
            r_req_re   <= dcache_re;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_din[8*i +: 8];
                end
            end
        end
    end

    // Samples the pre-write word, giving read-before-write on combined requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= '0;
        end else if (w_commit && w_op_re) begin
            r_dout <= r_mem[w_idx];
        end
    end

    assign dcache_dout = r_dout;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, scoreboarded reads.
// With DMEM_RESP_RANDOM_STALL_EN defined, stall lengths follow a reference LFSR.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr, din, dout;
    logic [3:0]  we;
    logic        re, stall;
    logic [31:0] addr0, din0, dout0;
    logic [3:0]  we0;
    logic        re0, stall0;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp0_q[$];
    logic [31:0] held = 32'h0;
    logic [31:0] held0 = 32'h0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dcache_addr (addr),
        .dcache_we   (we),
        .dcache_re   (re),
        .dcache_din  (din),
        .dcache_dout (dout),
        .stall       (stall)
    );

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(0)) u_dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .dcache_addr (addr0),
        .dcache_we   (we0),
        .dcache_re   (re0),
        .dcache_din  (din0),
        .dcache_dout (dout0),
        .stall       (stall0)
    );

`ifdef DMEM_RESP_RANDOM_STALL_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request to the LATENCY=2 instance in an IDLE cycle and wait for completion.
    task automatic req(input string tag, input logic [31:0] a, input logic [3:0] w,
                       input logic r, input logic [31:0] d, input logic [31:0] rd_exp);
        int n;
        int exp_n;
        exp_n = 2;
`ifdef DMEM_RESP_RANDOM_STALL_EN
        exp_n += int'(m_lfsr[1:0]);
`endif
        addr = a; we = w; re = r; din = d;
        if (r) exp_q.push_back(rd_exp);
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, " stall cycles"}, 32'(n), 32'(exp_n));
        if (r && exp_q.size() > 0) held = exp_q.pop_front();
        check({tag, " dout"}, dout, held);
        @(posedge clk); #1;
        we = 4'h0; re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        addr = '0; din = '0; we = '0; re = 1'b0;
        addr0 = '0; din0 = '0; we0 = '0; re0 = 1'b0;
        #12;
        check("reset dout", dout, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset dout0", dout0, 32'h0);
        check("reset stall0", {31'h0, stall0}, 32'h0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        req("wr5", 32'd5, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0);
        req("rd5", 32'd5, 4'h0, 1'b1, 32'h0, 32'hDEADBEEF);
        req("wr7", 32'd7, 4'hF, 1'b0, 32'h11223344, 32'h0);
        req("wr7 lanes", 32'd7, 4'b0101, 1'b0, 32'hAABBCCDD, 32'h0);
        req("rd7", 32'd7, 4'h0, 1'b1, 32'h0, 32'h11BB33DD);
        req("wr wrap", 32'h1003, 4'hF, 1'b0, 32'h5, 32'h0);
        req("rd3", 32'd3, 4'h0, 1'b1, 32'h0, 32'h5);
        req("rmw3", 32'd3, 4'hF, 1'b1, 32'h77, 32'h5);
        req("rd3 new", 32'd3, 4'h0, 1'b1, 32'h0, 32'h77);

`ifndef DMEM_RESP_RANDOM_STALL_EN
        // LATENCY=0: writes then back-to-back reads, one cycle per request.
        @(posedge clk); #1;
        addr0 = 32'd1; we0 = 4'hF; din0 = 32'hA1A10001;
        @(negedge clk); check("l0 wr1 stall", {31'h0, stall0}, 32'h0);
        @(posedge clk); #1;
        addr0 = 32'd2; din0 = 32'hB2B20002;
        @(negedge clk); check("l0 wr2 stall", {31'h0, stall0}, 32'h0);
        @(posedge clk); #1;
        we0 = 4'h0; re0 = 1'b1; addr0 = 32'd1; exp0_q.push_back(32'hA1A10001);
        @(negedge clk);
        check("l0 rd1 stall", {31'h0, stall0}, 32'h0);
        check("l0 hold before read", dout0, held0);
        @(posedge clk); #1;
        addr0 = 32'd2; exp0_q.push_back(32'hB2B20002);
        @(negedge clk);
        check("l0 rd2 stall", {31'h0, stall0}, 32'h0);
        if (exp0_q.size() > 0) held0 = exp0_q.pop_front();
        check("l0 rd1 dout", dout0, held0);
        @(posedge clk); #1;
        re0 = 1'b0;
        @(negedge clk);
        if (exp0_q.size() > 0) held0 = exp0_q.pop_front();
        check("l0 rd2 dout", dout0, held0);
        check("l0 idle stall", {31'h0, stall0}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l0 dout held", dout0, held0);
        @(posedge clk); #1;
`else
        for (int i = 0; i < 100; i++) begin
            req("rnd rd3", 32'd3, 4'h0, 1'b1, 32'h0, 32'h77);
        end
`endif

        // Reset during the first BUSY cycle of a write must drop it.
        req("wr9 zero", 32'd9, 4'hF, 1'b0, 32'h0, 32'h0);
        addr = 32'd9; we = 4'hF; din = 32'hFFFFFFFF; re = 1'b0;
        @(negedge clk);
        check("rst accept stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst stall", {31'h0, stall}, 32'h0);
        check("rst dout", dout, 32'h0);
        we = 4'h0;
        held = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        req("rd9 after rst", 32'd9, 4'h0, 1'b1, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
